// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and shared-memory signals of the memory arbiter
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem
    );
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between fetch and data stages
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        gnt_dm, last_dm, pick_dm, we_q, any_req;
    logic [31:0] addr_q, wdata_q, if_rdata_q, dm_rdata_q;
    assign any_req = bus.if_req | bus.dm_req;
    // on a tie, data wins unless data was the last one served
    assign pick_dm = bus.dm_req & (~bus.if_req | ~last_dm);
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    always_comb
        state_nx = state == IDLE   ? (any_req ? ACCESS : IDLE) :
                   state == ACCESS ? (cnt == 4'd0 ? DONE : ACCESS) : IDLE;
    always_comb begin
        bus.mem_en   = state == ACCESS;
        bus.mem_we   = state == ACCESS && we_q;
        bus.if_ready = state == DONE && !gnt_dm;
        bus.dm_ready = state == DONE && gnt_dm;
    end
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.stall_if  = bus.if_req & ~(state == DONE && !gnt_dm);
    assign bus.stall_mem = bus.dm_req & ~(state == DONE && gnt_dm);
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 4'd0;
            gnt_dm     <= 1'b0;
            last_dm    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                gnt_dm  <= pick_dm;
                we_q    <= pick_dm & bus.dm_we;
                addr_q  <= pick_dm ? bus.dm_addr : bus.if_addr;
                wdata_q <= pick_dm ? bus.dm_wdata : '0;
                cnt     <= 4'(WAIT_CYCLES - 1);
            end
            if (state == ACCESS) begin
                cnt <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
                if (cnt == 4'd0 && !gnt_dm)
                    if_rdata_q <= bus.mem_rdata;
                if (cnt == 4'd0 && gnt_dm && !we_q)
                    dm_rdata_q <= bus.mem_rdata;
            end
            if (state == DONE)
                last_dm <= gnt_dm;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and memory checked against an interval-based reference model
module tb_mem_arbiter;
    localparam int W = 2;
    localparam int N = 2000;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;
    mem_arbiter_if bus();
    mem_arbiter_if bus1();
    mem_arbiter #(.WAIT_CYCLES(W)) dut  (.clk(clk), .reset(reset), .bus(bus));
    mem_arbiter #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));
    int n_cmp = 0;
    int n_bad = 0;
    int g = -100;
    bit g_dm, g_we, last_dm, if_pend, dm_pend, rst_c, prev_rst, acc, dn, if_done_p, dm_done_p;
    logic [31:0] g_addr, g_wdata;
    logic [31:0] e_if = '0;
    logic [31:0] e_dm = '0;
    logic [31:0] mem_m [logic [31:0]];
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask
    function automatic logic [31:0] rd(logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : a ^ 32'hA5A5_0F0F;
    endfunction
    function automatic logic [31:0] pick_addr();
        return 32'h1001_0000 + 32'(4 * $urandom_range(0, 7));
    endfunction
    initial begin
        {bus.if_req, bus.dm_req, bus.dm_we} = '0;
        {bus.if_addr, bus.dm_addr, bus.dm_wdata, bus.mem_rdata} = '0;
        {bus1.if_req, bus1.dm_req, bus1.dm_we} = '0;
        {bus1.if_addr, bus1.dm_addr, bus1.dm_wdata, bus1.mem_rdata} = '0;
        prev_rst = 1'b1;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            rst_c = c < 2 || $urandom_range(0, 199) == 0;
            reset = rst_c;
            if (if_done_p) if_pend = 1'b0;
            if (!if_pend) begin
                if ($urandom_range(0, 2) == 0) begin
                    if_pend = 1'b1;
                    bus.if_addr = pick_addr();
                end
            end else if ($urandom_range(0, 15) == 0) if_pend = 1'b0;
            else if ($urandom_range(0, 3) == 0) bus.if_addr = pick_addr();
            if (dm_done_p) dm_pend = 1'b0;
            if (!dm_pend) begin
                if ($urandom_range(0, 2) == 0) begin
                    dm_pend = 1'b1;
                    bus.dm_addr = pick_addr();
                    bus.dm_we = $urandom_range(0, 1) == 1;
                    bus.dm_wdata = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) dm_pend = 1'b0;
            else if ($urandom_range(0, 3) == 0) begin
                bus.dm_addr = pick_addr();
                bus.dm_we = $urandom_range(0, 1) == 1;
                bus.dm_wdata = $urandom;
            end
            bus.if_req = if_pend;
            bus.dm_req = dm_pend;
            bus.mem_rdata = rd(bus.mem_addr);
            #1;
            acc = c >= g + 1 && c <= g + W;
            dn  = c == g + W + 1;
            if (prev_rst) begin
                check("rst_mem_addr", bus.mem_addr, 32'h0);
                check("rst_mem_wdata", bus.mem_wdata, 32'h0);
            end
            check("mem_en", 32'(bus.mem_en), 32'(acc));
            check("mem_we", 32'(bus.mem_we), 32'(acc && g_we));
            if (acc) check("mem_addr", bus.mem_addr, g_addr);
            if (acc && g_we) check("mem_wdata", bus.mem_wdata, g_wdata);
            check("if_ready", 32'(bus.if_ready), 32'(dn && !g_dm));
            check("dm_ready", 32'(bus.dm_ready), 32'(dn && g_dm));
            check("if_rdata", bus.if_rdata, e_if);
            check("dm_rdata", bus.dm_rdata, e_dm);
            check("stall_if", 32'(bus.stall_if), 32'(if_pend && !(dn && !g_dm)));
            check("stall_mem", 32'(bus.stall_mem), 32'(dm_pend && !(dn && g_dm)));
            if_done_p = dn && !g_dm;
            dm_done_p = dn && g_dm;
            if (rst_c) begin
                g = -100;
                last_dm = 1'b0;
                e_if = '0;
                e_dm = '0;
            end else begin
                if (c == g + W) begin
                    if (!g_dm) e_if = rd(g_addr);
                    else if (!g_we) e_dm = rd(g_addr);
                    else mem_m[g_addr] = g_wdata;
                end
                if (dn) last_dm = g_dm;
                if (c >= g + W + 2 && (if_pend || dm_pend)) begin
                    g_dm    = dm_pend && (!if_pend || !last_dm);
                    g       = c;
                    g_we    = g_dm && bus.dm_we;
                    g_addr  = g_dm ? bus.dm_addr : bus.if_addr;
                    g_wdata = bus.dm_wdata;
                end
            end
            prev_rst = rst_c;
        end
        reset = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        bus1.dm_req = 1'b1;
        bus1.dm_addr = 32'h1001_0004;
        @(negedge clk);
        check("w1_en_c1", 32'(bus1.mem_en), 32'h1);
        check("w1_addr_c1", bus1.mem_addr, 32'h1001_0004);
        check("w1_ready_c1", 32'(bus1.dm_ready), 32'h0);
        bus1.mem_rdata = 32'h0000_002A;
        @(negedge clk);
        check("w1_en_c2", 32'(bus1.mem_en), 32'h0);
        check("w1_ready_c2", 32'(bus1.dm_ready), 32'h1);
        check("w1_rdata_c2", bus1.dm_rdata, 32'h0000_002A);
        bus1.dm_req = 1'b0;
        bus1.mem_rdata = '0;
        @(negedge clk);
        check("w1_ready_c3", 32'(bus1.dm_ready), 32'h0);
        check("w1_rdata_hold", bus1.dm_rdata, 32'h0000_002A);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, memory access length in cycles; legal range 1..15.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset; synchronous, active-high.
REQ-004 if_req  input  1  fetch-stage read request; held until if_ready.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_rdata  output  32  fetched instruction; valid while if_ready=1.
REQ-007 if_ready  output  1  one-cycle pulse marking fetch completion.
REQ-008 dm_req  input  1  MEM-stage data request; held until dm_ready.
REQ-009 dm_we  input  1  1 = store, 0 = load.
REQ-010 dm_addr  input  32  data byte address.
REQ-011 dm_wdata  input  32  store data.
REQ-012 dm_rdata  output  32  load data; valid while dm_ready=1.
REQ-013 dm_ready  output  1  one-cycle pulse marking data-access completion.
REQ-014 mem_en  output  1  shared single-port memory enable.
REQ-015 mem_we  output  1  shared memory write enable.
REQ-016 mem_addr  output  32  shared memory address.
REQ-017 mem_wdata  output  32  shared memory write data.
REQ-018 mem_rdata  input  32  shared memory read data.
REQ-019 stall_if  output  1  combinational: if_req & ~if_ready.
REQ-020 stall_mem  output  1  combinational: dm_req & ~dm_ready.

Function
REQ-021 FSM states: IDLE, ACCESS, DONE; no other state reachable.
REQ-022 IDLE, no request: remain IDLE; mem_en=0, mem_we=0.
REQ-023 IDLE, request present at cycle T: grant one requester; latch its address, write data and write enable (fetch: we=0); enter ACCESS at T+1.
REQ-024 Arbitration: a single requester is granted directly; when both request, the requester not granted last wins (round-robin on a last_grant register).
REQ-025 ACCESS: mem_en=1, mem_addr/mem_wdata/mem_we driven from the latched values only, held stable for exactly WAIT_CYCLES cycles (T+1..T+WAIT_CYCLES); 4-bit countdown counter loaded with WAIT_CYCLES-1 on grant.
REQ-026 Final ACCESS cycle (counter=0): capture mem_rdata into the granted requester's rdata register (loads and fetches only); enter DONE.
REQ-027 DONE (cycle T+WAIT_CYCLES+1): assert the granted requester's ready for exactly one cycle; update last_grant; return to IDLE; no grant is made in DONE.
REQ-028 Request-to-ready latency is WAIT_CYCLES+1 cycles; minimum spacing between grants is WAIT_CYCLES+2 cycles.
REQ-029 Store: mem_we=1 throughout ACCESS; dm_rdata retains its previous value; dm_ready still pulses.
REQ-030 Request dropped mid-access: access completes, ready pulse still issued, no retry.
REQ-031 Request inputs changing after grant have no effect on the in-flight access.
REQ-032 if_rdata/dm_rdata hold their last captured value outside their ready pulses.
REQ-033 if_ready and dm_ready are never asserted in the same cycle.

Reset
REQ-034 reset=1 at a posedge: state=IDLE, counter=0, last_grant=IF (data wins the first tie), mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0.
REQ-035 reset during ACCESS or DONE aborts the access: no ready pulse is issued and no mem_en is asserted the following cycle.
REQ-036 Requests are evaluated in the first cycle with reset=0.

Verification
REQ-037 WAIT_CYCLES=2, if_req=1, if_addr=0x00400000 at cycle 0, mem_rdata=0x20080005 at cycle 2 -> mem_en=1 at cycles 1-2, mem_addr=0x00400000, if_ready=1 with if_rdata=0x20080005 at cycle 3, stall_if=1 at cycles 0-2.
REQ-038 First request after reset with if_req=dm_req=1 at cycle 0 -> data granted, dm_ready at cycle 3; fetch granted at cycle 4, if_ready at cycle 7.
REQ-039 Store with dm_we=1, dm_addr=0x10010000, dm_wdata=0xDEADBEEF -> mem_en=mem_we=1 with those values at cycles 1-2, dm_ready at cycle 3, dm_rdata unchanged.
REQ-040 Both requesters held high continuously for 4 grants -> grant order D, I, D, I; ready pulses at cycles 3, 7, 11, 15.
REQ-041 reset asserted at cycle 2 of a data access -> mem_en=0 at cycle 3, no dm_ready; next tie is granted to data.
REQ-042 WAIT_CYCLES=1, dm load from 0x10010004, mem_rdata=0x0000002A at cycle 1 -> mem_en=1 at cycle 1 only, dm_ready=1 with dm_rdata=0x0000002A at cycle 2.
